// File: rtl/nanci_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nanci_phase_ctrl
// Purpose  : Shearsort step sequencer for the Nanci PE mesh. It alternates
//            row and column phases, then runs a compute window and pulses done.
//            Optional macro NANCI_PHASE_STALL_EN adds i_stall (freeze sequencing).
// Revision : 1.0 - initial release
// ============================================================================
module nanci_phase_ctrl #(
    parameter int SQRT_N         = 1,
    parameter int SORT_CYCLES    = 4,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
`ifdef NANCI_PHASE_STALL_EN
    input  logic       i_stall,
`endif
    output logic       o_busy,
    output logic       o_step_valid,
    output logic       o_row_phase,
    output logic       o_parity,
    output logic [4:0] o_phase_idx,
    output logic       o_compute,
    output logic       o_done
);

    localparam int c_step_w = $clog2(SORT_CYCLES + 1);
    localparam int c_cmp_w  = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(SORT_CYCLES - 1);
    localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);
    localparam logic [c_cmp_w-1:0]  c_cmp_last  = c_cmp_w'(COMPUTE_CYCLES - 1);
    localparam logic [c_cmp_w-1:0]  c_cmp_one   = c_cmp_w'(1);
    localparam logic [4:0]          c_phase_last = 5'(2 * SQRT_N);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_row     = 3'd1;
    localparam logic [2:0] c_st_col     = 3'd2;
    localparam logic [2:0] c_st_compute = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_step_w-1:0] r_step;
    logic [c_step_w-1:0] w_step_nxt;
    logic [4:0]          r_phase_idx;
    logic [4:0]          w_phase_nxt;
    logic [c_cmp_w-1:0]  r_cmp;
    logic [c_cmp_w-1:0]  w_cmp_nxt;
    logic                w_active;
    logic                w_stall;

    assign w_active = (r_state == c_st_row) || (r_state == c_st_col) ||
                      (r_state == c_st_compute);

`ifdef NANCI_PHASE_STALL_EN
    assign w_stall = i_stall && w_active;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_step      <= '0;
            r_phase_idx <= '0;
            r_cmp       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_phase_idx <= w_phase_nxt;
            r_cmp       <= w_cmp_nxt;
        end
    end

    // A stall simply skips the whole update, so everything holds.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_phase_nxt = r_phase_idx;
        w_cmp_nxt   = r_cmp;
        if (!w_stall) begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        w_state_nxt = c_st_row;
                        w_step_nxt  = '0;
                        w_phase_nxt = '0;
                    end
                end
                c_st_row, c_st_col: begin
                    if (r_step == c_step_last) begin
                        w_step_nxt = '0;
                        if (r_phase_idx == c_phase_last) begin
                            w_state_nxt = c_st_compute;
                        end else begin
                            w_phase_nxt = r_phase_idx + 5'd1;
                            w_state_nxt = (r_state == c_st_row) ? c_st_col : c_st_row;
                        end
                    end else begin
                        w_step_nxt = r_step + c_step_one;
                    end
                end
                c_st_compute: begin
                    if (r_cmp == c_cmp_last) begin
                        w_cmp_nxt   = '0;
                        w_state_nxt = c_st_done;
                    end else begin
                        w_cmp_nxt = r_cmp + c_cmp_one;
                    end
                end
                c_st_done: begin
                    w_state_nxt = c_st_idle;
                    w_phase_nxt = '0;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_step_nxt  = '0;
                    w_phase_nxt = '0;
                    w_cmp_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_busy       = (r_state != c_st_idle);
        o_step_valid = ((r_state == c_st_row) || (r_state == c_st_col)) && !w_stall;
        o_row_phase  = (r_state == c_st_row);
        o_parity     = r_step[0];
        o_phase_idx  = r_phase_idx;
        o_compute    = (r_state == c_st_compute) && !w_stall;
        o_done       = (r_state == c_st_done);
    end

endmodule
`default_nettype wire

// File: tb/tb_nanci_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanci_phase_ctrl
// Purpose  : Directed bench for nanci_phase_ctrl (full-run and single-PE builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nanci_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, rst_b, start_b;
    logic       stall_a;
    logic       busy_a, sv_a, rp_a, par_a, cmp_a, done_a;
    logic       busy_b, sv_b, rp_b, par_b, cmp_b, done_b;
    logic [4:0] idx_a, idx_b;
    logic [5:0] flags_a, flags_b;

    int n_cmp = 0;
    int n_err = 0;

    // flags = {busy, step_valid, row_phase, parity, compute, done}
    assign flags_a = {busy_a, sv_a, rp_a, par_a, cmp_a, done_a};
    assign flags_b = {busy_b, sv_b, rp_b, par_b, cmp_b, done_b};

    nanci_phase_ctrl #(.SQRT_N(1), .SORT_CYCLES(2), .COMPUTE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a), .i_start(start_a),
`ifdef NANCI_PHASE_STALL_EN
        .i_stall(stall_a),
`endif
        .o_busy(busy_a), .o_step_valid(sv_a), .o_row_phase(rp_a), .o_parity(par_a),
        .o_phase_idx(idx_a), .o_compute(cmp_a), .o_done(done_a)
    );

    nanci_phase_ctrl #(.SQRT_N(0), .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .i_start(start_b),
`ifdef NANCI_PHASE_STALL_EN
        .i_stall(1'b0),
`endif
        .o_busy(busy_b), .o_step_valid(sv_b), .o_row_phase(rp_b), .o_parity(par_b),
        .o_phase_idx(idx_b), .o_compute(cmp_b), .o_done(done_b)
    );

    task automatic chk_f(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: flags got %b want %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_i(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: phase_idx got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    // SQRT_N=1, SORT_CYCLES=2, COMPUTE_CYCLES=1; start sampled at end of cycle 0.
    function automatic logic [5:0] exp_full(input int k);
        case (k)
            1: return 6'b111000;
            2: return 6'b111100;
            3: return 6'b110000;
            4: return 6'b110100;
            5: return 6'b111000;
            6: return 6'b111100;
            7: return 6'b100010;
            8: return 6'b100001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [4:0] exp_idx_full(input int k);
        if (k <= 2) return 5'd0;
        if (k <= 4) return 5'd1;
        return 5'd2;
    endfunction

    // Same run with i_stall high during cycles 3..5 (column phase frozen).
    function automatic logic [5:0] exp_stall(input int k);
        case (k)
            1: return 6'b111000;
            2: return 6'b111100;
            3, 4, 5: return 6'b100000;
            6: return 6'b110000;
            7: return 6'b110100;
            8: return 6'b111000;
            9: return 6'b111100;
            10: return 6'b100010;
            11: return 6'b100001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [4:0] exp_idx_stall(input int k);
        if (k <= 2) return 5'd0;
        if (k <= 7) return 5'd1;
        return 5'd2;
    endfunction

    // mode 0: start pulse; 1: extra start at cycle 3; 2: start held; 3: stall 3..5
    task automatic run_a(input int mode, input int ncyc);
        logic [5:0] ev;
        logic [4:0] ei;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            case (mode)
                1:       start_a = (k == 0) || (k == 3);
                2:       start_a = 1'b1;
                default: start_a = (k == 0);
            endcase
            stall_a = (mode == 3) && (k >= 3) && (k <= 5);
            if (mode == 3) begin
                ev = exp_stall(k);
                ei = exp_idx_stall(k);
            end else if (mode == 2 && k == 10) begin
                ev = 6'b111000;
                ei = 5'd0;
            end else begin
                ev = exp_full(k);
                ei = exp_idx_full(k);
            end
            #1;
            chk_f($sformatf("run_m%0d_c%0d", mode, k), flags_a, ev);
            if (ev[4] || ev == 6'b000000)
                chk_i($sformatf("idx_m%0d_c%0d", mode, k), idx_a, (ev[4] ? ei : 5'd0));
        end
        start_a = 1'b0;
        stall_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_f("reset_a", flags_a, 6'b000000);
        chk_i("reset_idx_a", idx_a, 5'd0);
        chk_f("reset_b", flags_b, 6'b000000);
        chk_i("reset_idx_b", idx_b, 5'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        run_a(0, 10);
        run_a(1, 10);

        // Start held through DONE: the next run begins at cycle 10.
        run_a(2, 11);
        saw_done = 1'b0;
        for (int k = 0; k < 20 && !saw_done; k++) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        n_cmp++;
        assert (saw_done) else begin
            n_err++;
            $error("FAIL held_run_done: done seen %0b want 1", saw_done);
        end
        @(negedge clk);
        chk_f("held_run_idle", flags_a, 6'b000000);

        // Asynchronous reset mid-run at cycle 4.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk_f("midrst_flags", flags_a, 6'b000000);
        chk_i("midrst_idx", idx_a, 5'd0);
        @(negedge clk); rst_a = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_a || busy_a) saw_done = 1'b1;
        end
        n_cmp++;
        assert (!saw_done) else begin
            n_err++;
            $error("FAIL midrst_quiet: activity seen %0b want 0", saw_done);
        end
        run_a(0, 10);

        // Single-PE build: step at 1, compute at 2, done at 3.
        for (int k = 0; k < 5; k++) begin
            logic [5:0] ev;
            @(negedge clk);
            start_b = (k == 0);
            case (k)
                1: ev = 6'b111000;
                2: ev = 6'b100010;
                3: ev = 6'b100001;
                default: ev = 6'b000000;
            endcase
            #1;
            chk_f($sformatf("single_c%0d", k), flags_b, ev);
            if (k == 1) chk_i("single_idx", idx_b, 5'd0);
        end
        start_b = 1'b0;

`ifdef NANCI_PHASE_STALL_EN
        run_a(3, 13);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
